bht_gshare: RTL

- Parametrised successor to the 16-entry pc[3:0]-indexed branch history table used by the 5-stage MIPS pipeline.
- Provides a tagged BTB with configurable depth and N-bit saturating counters.
- Supports a selectable bimodal or gshare index, with a speculative global history register (GHR) that is repaired on mispredict.
- Lookup is driven from the IF-stage PC. Update is driven from EX-stage branch resolution (the selm/mispredict path).

---
 rtl/bht_gshare_if.sv | 48 ++++
 rtl/bht_gshare.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/bht_gshare_if.sv
// -----------------------------------------------------------------------------
// bht_gshare_if
// Bundles the lookup, update and statistics signals of the branch predictor.
//
//   Lookup (IF stage):  lk_valid, lk_pc
//                       pred_hit, pred_taken, pred_target, pred_ghr
//   Update (EX stage):  upd_valid, upd_pc, upd_ghr, upd_taken,
//                       upd_target, upd_mispredict
//   Statistics:         stat_updates, stat_mispredicts
//
// master : the pipeline side (drives lookups and resolutions)
// slave  : the predictor side
// -----------------------------------------------------------------------------
interface bht_gshare_if #(
  parameter int ADDR_W = 32,
  parameter int GHR_W  = 4
);
  logic              lk_valid;
  logic [ADDR_W-1:0] lk_pc;
  logic              pred_hit;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;
  logic [GHR_W-1:0]  pred_ghr;

  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic [GHR_W-1:0]  upd_ghr;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;
  logic              upd_mispredict;

  logic [31:0]       stat_updates;
  logic [31:0]       stat_mispredicts;

  modport master (
    output lk_valid, lk_pc,
    output upd_valid, upd_pc, upd_ghr, upd_taken, upd_target, upd_mispredict,
    input  pred_hit, pred_taken, pred_target, pred_ghr,
    input  stat_updates, stat_mispredicts
  );

  modport slave (
    input  lk_valid, lk_pc,
    input  upd_valid, upd_pc, upd_ghr, upd_taken, upd_target, upd_mispredict,
    output pred_hit, pred_taken, pred_target, pred_ghr,
    output stat_updates, stat_mispredicts
  );
endinterface

// File: rtl/bht_gshare.sv
// -----------------------------------------------------------------------------
// bht_gshare
// Tagged branch target buffer with saturating direction counters and an
// optional gshare index. A speculative global history register (GHR) is
// shifted on every predicted hit and repaired from the snapshot carried with
// a mispredicted branch.
//
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - asynchronous active-high reset
//   bus  - bht_gshare_if.slave: IF-stage lookup, EX-stage update, statistics
//
// Optional feature macro: BHT_GSHARE_STATS_EN
//   defined   -> stat_updates / stat_mispredicts count update / mispredict edges
//   undefined -> both statistics outputs are constant 0 (no counter flops)
//
// Requires CTR_W >= 2 and 2 <= GHR_W <= IDX_W.
// -----------------------------------------------------------------------------
module bht_gshare #(
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 4,
  parameter int TAG_W  = 8,
  parameter int CTR_W  = 2,
  parameter int GHR_W  = 4,
  parameter int GSHARE = 1
) (
  input logic       clk,
  input logic       rst,
  bht_gshare_if.slave bus
);

  localparam int DEPTH = 1 << IDX_W;

  localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_WNT = {1'b0, {(CTR_W-1){1'b1}}};
  localparam logic [CTR_W-1:0] CTR_WT  = {1'b1, {(CTR_W-1){1'b0}}};

  // Table state. Every entry is cleared on reset, so the arrays are flops.
  logic              valid_q [DEPTH];
  logic [TAG_W-1:0]  tag_q   [DEPTH];
  logic [CTR_W-1:0]  ctr_q   [DEPTH];
  logic [ADDR_W-1:0] tgt_q   [DEPTH];

  logic [GHR_W-1:0]  ghr_q;
  logic [GHR_W-1:0]  ghr_d;

  // Word-aligned PC index, optionally folded with history.
  function automatic logic [IDX_W-1:0] make_idx(input logic [ADDR_W-1:0] pc,
                                                input logic [GHR_W-1:0]  ghr);
    logic [IDX_W-1:0] pidx;
    pidx = pc[IDX_W+1:2];
    if (GSHARE != 0) return pidx ^ IDX_W'(ghr);
    else             return pidx;
  endfunction

  // ---------------------------------------------------------------------------
  // Lookup: purely combinational on the current (pre-edge) table contents,
  // which gives read-before-write against a same-cycle update.
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic             lk_taken;

  assign lk_idx   = make_idx(bus.lk_pc, ghr_q);
  assign lk_tag   = bus.lk_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign lk_hit   = bus.lk_valid & valid_q[lk_idx] & (tag_q[lk_idx] == lk_tag);
  assign lk_taken = lk_hit & ctr_q[lk_idx][CTR_W-1];

  assign bus.pred_hit    = lk_hit;
  assign bus.pred_taken  = lk_taken;
  assign bus.pred_target = lk_hit ? tgt_q[lk_idx] : '0;
  assign bus.pred_ghr    = ghr_q;

  // ---------------------------------------------------------------------------
  // Update decode: indexed with the history the branch was predicted under.
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic [CTR_W-1:0] upd_ctr_cur;
  logic [CTR_W-1:0] upd_ctr_next;

  assign upd_idx     = make_idx(bus.upd_pc, bus.upd_ghr);
  assign upd_tag     = bus.upd_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_hit     = bus.upd_valid & valid_q[upd_idx] & (tag_q[upd_idx] == upd_tag);
  assign upd_ctr_cur = ctr_q[upd_idx];

  // Saturating step; never wraps at either end.
  always_comb begin
    upd_ctr_next = upd_ctr_cur;
    if (bus.upd_taken) begin
      if (upd_ctr_cur != CTR_MAX) upd_ctr_next = upd_ctr_cur + CTR_W'(1);
    end else begin
      if (upd_ctr_cur != '0)      upd_ctr_next = upd_ctr_cur - CTR_W'(1);
    end
  end

  // GHR: a mispredict repair rebuilds history from the branch's snapshot plus
  // its real outcome, and overrides any speculative shift on the same edge.
  always_comb begin
    ghr_d = ghr_q;
    if (bus.upd_valid & bus.upd_mispredict)
      ghr_d = {bus.upd_ghr[GHR_W-2:0], bus.upd_taken};
    else if (lk_hit)
      ghr_d = {ghr_q[GHR_W-2:0], lk_taken};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        ctr_q[i]   <= CTR_WNT;
        tgt_q[i]   <= '0;
      end
    end else begin
      ghr_q <= ghr_d;
      if (upd_hit) begin
        ctr_q[upd_idx] <= upd_ctr_next;
        if (bus.upd_taken) tgt_q[upd_idx] <= bus.upd_target;
      end else if (bus.upd_valid & bus.upd_taken) begin
        // Allocate on a taken miss; the previous occupant is simply replaced.
        valid_q[upd_idx] <= 1'b1;
        tag_q[upd_idx]   <= upd_tag;
        tgt_q[upd_idx]   <= bus.upd_target;
        ctr_q[upd_idx]   <= CTR_WT;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
`ifdef BHT_GSHARE_STATS_EN
  logic [31:0] stat_upd_q;
  logic [31:0] stat_mis_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_upd_q <= '0;
      stat_mis_q <= '0;
    end else if (bus.upd_valid) begin
      stat_upd_q <= stat_upd_q + 32'd1;
      if (bus.upd_mispredict) stat_mis_q <= stat_mis_q + 32'd1;
    end
  end

  assign bus.stat_updates     = stat_upd_q;
  assign bus.stat_mispredicts = stat_mis_q;
`else
  assign bus.stat_updates     = 32'd0;
  assign bus.stat_mispredicts = 32'd0;
`endif

  // PC bits outside the index/tag fields carry no information for the table.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.lk_pc[1:0],  bus.lk_pc[ADDR_W-1:IDX_W+TAG_W+2],
                            bus.upd_pc[1:0], bus.upd_pc[ADDR_W-1:IDX_W+TAG_W+2]};

endmodule
